// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: instruction-sequencing FSM plus conditional-execution gating.
// Optional FP coprocessor handshake (EXECUTEF/FPWB states) enabled by defining FPU_CTRL_EN.
module multicycle_controller #(
  parameter int unsigned ALUCTRL_W  = 4,
  parameter int unsigned FP_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 fp_done,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 fp_start,
  output logic                 fp_timeout
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
`ifdef FPU_CTRL_EN
    , S_EXECUTEF,
    S_FPWB
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd_pc;

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign funct = Instr[13:8];
  assign rd_pc = (Instr[3:0] == 4'hF);

  logic unused_rn;
  assign unused_rn = ^Instr[7:4];

`ifdef FPU_CTRL_EN
  logic [7:0] fp_cnt_q, fp_cnt_d;
  logic       fp_timeout_q, fp_timeout_d;
  assign fp_timeout = fp_timeout_q;
`else
  logic unused_fp_done;
  assign unused_fp_done = fp_done;
  assign fp_timeout     = 1'b0;
`endif

  // Condition evaluation against the stored flags {N,Z,C,V}
  logic cond_ex;
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0:    cond_ex = fz;
      4'h1:    cond_ex = ~fz;
      4'h2:    cond_ex = fc;
      4'h3:    cond_ex = ~fc;
      4'h4:    cond_ex = fn;
      4'h5:    cond_ex = ~fn;
      4'h6:    cond_ex = fv;
      4'h7:    cond_ex = ~fv;
      4'h8:    cond_ex = fc & ~fz;
      4'h9:    cond_ex = ~fc | fz;
      4'hA:    cond_ex = (fn == fv);
      4'hB:    cond_ex = (fn != fv);
      4'hC:    cond_ex = ~fz & (fn == fv);
      4'hD:    cond_ex = fz | (fn != fv);
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ALU command decode from Funct[4:1]
  logic [1:0] cmd_sel;
  logic       no_write;
  logic       arith;

  always_comb begin
    cmd_sel  = 2'd0;
    no_write = 1'b0;
    arith    = 1'b0;
    case (funct[4:1])
      4'b0100: begin cmd_sel = 2'd0; arith = 1'b1; end
      4'b0010: begin cmd_sel = 2'd1; arith = 1'b1; end
      4'b0000: cmd_sel = 2'd2;
      4'b1100: cmd_sel = 2'd3;
      4'b1010: begin cmd_sel = 2'd1; arith = 1'b1; no_write = 1'b1; end
      default: no_write = 1'b1;
    endcase
  end

  logic [1:0] alu_sel;
  logic       wb_en;

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
`ifdef FPU_CTRL_EN
    fp_cnt_d     = fp_cnt_q;
    fp_timeout_d = fp_timeout_q;
`endif
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_sel   = 2'd0;
    fp_start  = 1'b0;
    wb_en     = 1'b0;

    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      // CondEx is frozen here so a flag-setting instruction gates its own
      // writeback with the flags it saw, not the ones it just produced.
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        cond_ex_d = cond_ex;
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
`ifdef FPU_CTRL_EN
          default: begin
            state_d  = S_EXECUTEF;
            fp_cnt_d = '0;
          end
`else
          default: state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        wb_en     = cond_ex_q;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_q;
        state_d  = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcB = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        alu_sel = cmd_sel;
        state_d = S_ALUWB;
        if (funct[0] && cond_ex_q) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (arith) flags_d[1:0] = ALUFlags[1:0];
        end
      end
      S_ALUWB: begin
        wb_en   = cond_ex_q & ~no_write;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex_q;
        state_d   = S_FETCH;
      end
`ifdef FPU_CTRL_EN
      S_EXECUTEF: begin
        fp_start = cond_ex_q && (fp_cnt_q == 8'd0);
        if (!cond_ex_q) begin
          state_d = S_FETCH;
        end else if (fp_done) begin
          state_d = S_FPWB;
        end else if (fp_cnt_q + 8'd1 == 8'(FP_TIMEOUT)) begin
          fp_timeout_d = 1'b1;
          state_d      = S_FETCH;
        end else begin
          fp_cnt_d = fp_cnt_q + 8'd1;
        end
      end
      S_FPWB: begin
        wb_en   = cond_ex_q;
        state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    if (wb_en) begin
      RegWrite = 1'b1;
      PCWrite  = rd_pc;
    end
  end

  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign ImmSrc     = op;
  assign ALUControl = ALUCTRL_W'(alu_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
`ifdef FPU_CTRL_EN
      fp_cnt_q     <= '0;
      fp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
`ifdef FPU_CTRL_EN
      fp_cnt_q     <= fp_cnt_d;
      fp_timeout_q <= fp_timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle sequences from an ISA-level model.
// Compile with FPU_CTRL_EN defined to exercise the FP handshake as well.
module tb_multicycle_controller;

  localparam int unsigned FPT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        fp_done;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [3:0]  ALUControl;
  logic        fp_start, fp_timeout;

  always #5 clk = ~clk;

  multicycle_controller #(.ALUCTRL_W(4), .FP_TIMEOUT(FPT)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .fp_done(fp_done),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .fp_start(fp_start), .fp_timeout(fp_timeout)
  );

  logic [20:0] obs;
  assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSrc, ALUControl, fp_start, fp_timeout};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural model state
  bit [3:0]    m_flags;
  bit          m_tmo;
  logic [19:0] cur;
  logic [20:0] exp_q[$];
  logic [3:0]  af_q[$];
  logic        fd_q[$];

  function automatic bit cond_true(input logic [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic logic [20:0] mk(input bit pcw, input bit mw, input bit rw, input bit irw,
                                     input bit adr, input bit [1:0] a, input bit [1:0] b,
                                     input bit [1:0] res, input bit [3:0] alu, input bit fps);
    return {pcw, mw, rw, irw, adr, cur[15:14] == 2'b01, cur[15:14] == 2'b10, a, b, res,
            cur[15:14], alu, fps, m_tmo};
  endfunction

  task automatic push(input logic [20:0] v, input logic [3:0] af, input logic fd);
    exp_q.push_back(v);
    af_q.push_back(af);
    fd_q.push_back(fd);
  endtask

  task automatic build(input logic [19:0] ins, input logic [3:0] ef, input int done_at);
    bit ce, pcrd, wr, nowr, arith;
    bit [3:0] alu;
    logic [5:0] fn;
    exp_q.delete(); af_q.delete(); fd_q.delete();
    cur  = ins;
    fn   = ins[13:8];
    pcrd = (ins[3:0] == 4'hF);
    ce   = cond_true(ins[19:16], m_flags);
    push(mk(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 4'd0, 0), 4'($urandom), 1'($urandom));
    push(mk(0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd2, 4'd0, 0), 4'($urandom), 1'($urandom));
    case (ins[15:14])
      2'b01: begin
        push(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 4'd0, 0), 4'($urandom), 1'($urandom));
        if (fn[0]) begin
          push(mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 0), 4'($urandom), 1'($urandom));
          push(mk(ce && pcrd, 0, ce, 0, 0, 2'd0, 2'd0, 2'd1, 4'd0, 0), 4'($urandom), 1'($urandom));
        end else begin
          push(mk(0, ce, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 0), 4'($urandom), 1'($urandom));
        end
      end
      2'b00: begin
        arith = 1'b0; nowr = 1'b0; alu = 4'd0;
        case (fn[4:1])
          4'b0100: arith = 1'b1;
          4'b0010: begin alu = 4'd1; arith = 1'b1; end
          4'b0000: alu = 4'd2;
          4'b1100: alu = 4'd3;
          4'b1010: begin alu = 4'd1; arith = 1'b1; nowr = 1'b1; end
          default: nowr = 1'b1;
        endcase
        push(mk(0, 0, 0, 0, 0, 2'd0, fn[5] ? 2'd1 : 2'd0, 2'd0, alu, 0), ef, 1'($urandom));
        if (fn[0] && ce) begin
          m_flags[3:2] = ef[3:2];
          if (arith) m_flags[1:0] = ef[1:0];
        end
        wr = ce && !nowr;
        push(mk(wr && pcrd, 0, wr, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0), 4'($urandom), 1'($urandom));
      end
      2'b10: push(mk(ce, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'd0, 0), 4'($urandom), 1'($urandom));
      default: begin
`ifdef FPU_CTRL_EN
        if (!ce) begin
          push(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0), 4'($urandom), 1'($urandom));
        end else begin
          for (int w = 0; w < 256; w++) begin
            push(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, w == 0), 4'($urandom), w == done_at);
            if (w == done_at) begin
              push(mk(pcrd, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0), 4'($urandom), 1'($urandom));
              break;
            end
            if (w + 1 == int'(FPT)) begin
              m_tmo = 1'b1;
              break;
            end
          end
        end
`endif
      end
    endcase
  endtask

  // Runs one instruction from FETCH; stop_after > 0 checks only that many cycles.
  task automatic run(input string tag, input logic [19:0] ins, input logic [3:0] ef,
                     input int done_at, input int stop_after);
    int n;
    build(ins, ef, done_at);
    Instr = ins;
    n = exp_q.size();
    if (stop_after > 0 && stop_after < n) n = stop_after;
    for (int k = 0; k < n; k++) begin
      ALUFlags = af_q[k];
      fp_done  = fd_q[k];
      @(negedge clk);
      chk($sformatf("%s ins=%h cyc%0d", tag, ins, k), 32'(obs), 32'(exp_q[k]));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    Instr    = '0;
    ALUFlags = '0;
    fp_done  = 1'b0;
    m_flags  = '0;
    m_tmo    = 1'b0;
    cur      = '0;
    #1;
    chk("reset_state", 32'(obs), 32'(mk(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 4'd0, 0)));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run("subs", 20'hE0511, 4'b0100, 0, 0);
    run("beq", 20'h0A000, 4'h0, 0, 0);
    run("bne", 20'h1A000, 4'h0, 0, 0);
    run("ldr", 20'hE5912, 4'h0, 0, 0);
    run("str", 20'hE5812, 4'h0, 0, 0);
    run("orr_pc", 20'hE381F, 4'h0, 0, 0);
    run("cmp", 20'hE1510, 4'b1001, 0, 0);
    run("addge", 20'hA0823, 4'h0, 0, 0);
    run("addlt", 20'hB0823, 4'h0, 0, 0);

    // Reset arriving while a load sits in MEMRD
    run("subs2", 20'hE0511, 4'b0100, 0, 0);
    run("ldr_rst", 20'hE591F, 4'h0, 0, 3);
    chk("pre_reset_memrd", 32'(obs), 32'(exp_q[3]));
    reset = 1'b1;
    m_flags = '0;
    m_tmo   = 1'b0;
    #2;
    chk("reset_mid_memrd", 32'(obs), 32'(mk(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 4'd0, 0)));
    @(posedge clk);
    #1;
    reset = 1'b0;
    run("beq_after_rst", 20'h0A000, 4'h0, 0, 0);
    run("bne_after_rst", 20'h1A000, 4'h0, 0, 0);

    run("fp_nop_or_issue", 20'hEC005, 4'h0, 3, 0);
    run("fp_never_done", 20'hEC006, 4'h0, 1000, 0);
    run("after_fp", 20'hE0511, 4'b0010, 0, 0);

    for (int i = 0; i < 400; i++) begin
      run("rnd", 20'($urandom), 4'($urandom), int'($urandom_range(0, 20)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
